// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects ALU and LSB results in two 2-entry FIFOs and
// broadcasts one per cycle on a registered CDB, round-robin on ties.
// A mispredict drops every buffered result; rdy low freezes everything.
module cdb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                mispredict,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_value,
    output logic                alu_ready,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_value,
    output logic                lsb_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_value,
    output logic                cdb_src
);
    localparam int         DEPTH = 2;
    localparam logic [1:0] FULL  = 2'(DEPTH);

    // index 0 = ALU, index 1 = LSB throughout
    logic                in_valid [2];
    logic [ROB_ID_W-1:0] in_tag   [2];
    logic [DATA_W-1:0]   in_value [2];
    logic                in_ready [2];

    logic [ROB_ID_W-1:0] tag_mem  [2][DEPTH];
    logic [DATA_W-1:0]   val_mem  [2][DEPTH];
    logic                head     [2];
    logic                tail     [2];
    logic [1:0]          cnt      [2];
    logic                last_grant;

    logic                accept;
    logic                push     [2];
    logic                pop      [2];
    logic                grant_any;
    logic                grant_src;

    assign in_valid[0] = alu_valid;
    assign in_tag[0]   = alu_rob_id;
    assign in_value[0] = alu_value;
    assign in_valid[1] = lsb_valid;
    assign in_tag[1]   = lsb_rob_id;
    assign in_value[1] = lsb_value;
    assign alu_ready   = in_ready[0];
    assign lsb_ready   = in_ready[1];
    assign accept      = rdy && !mispredict;

    // Ready looks only at registered occupancy; a same-cycle pop is not credited.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            in_ready[s] = accept && (cnt[s] != FULL);
            push[s]     = in_valid[s] && in_ready[s];
        end
    end

    // Pick a head from pre-edge state; on a tie the source not granted last wins.
    always_comb begin
        grant_any = (cnt[0] != 2'd0) || (cnt[1] != 2'd0);
        if ((cnt[0] != 2'd0) && (cnt[1] != 2'd0))
            grant_src = ~last_grant;
        else
            grant_src = (cnt[1] != 2'd0);
        pop[0] = accept && grant_any && !grant_src;
        pop[1] = accept && grant_any && grant_src;
    end

    // Per-source circular FIFOs; flush resets pointers only, stale data is unreachable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    tag_mem[s][e] <= '0;
                    val_mem[s][e] <= '0;
                end
                head[s] <= 1'b0;
                tail[s] <= 1'b0;
                cnt[s]  <= 2'd0;
            end
        end else if (rdy) begin
            if (mispredict) begin
                for (int s = 0; s < 2; s++) begin
                    head[s] <= 1'b0;
                    tail[s] <= 1'b0;
                    cnt[s]  <= 2'd0;
                end
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (push[s]) begin
                        tag_mem[s][tail[s]] <= in_tag[s];
                        val_mem[s][tail[s]] <= in_value[s];
                        tail[s]             <= ~tail[s];
                    end
                    if (pop[s])
                        head[s] <= ~head[s];
                    if (push[s] && !pop[s])
                        cnt[s] <= cnt[s] + 2'd1;
                    else if (!push[s] && pop[s])
                        cnt[s] <= cnt[s] - 2'd1;
                end
            end
        end
    end

    // Registered broadcast; tag/value/src hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (rdy) begin
            if (mispredict) begin
                cdb_valid  <= 1'b0;
                last_grant <= 1'b1;
            end else if (grant_any) begin
                cdb_valid  <= 1'b1;
                cdb_rob_id <= tag_mem[grant_src][head[grant_src]];
                cdb_value  <= val_mem[grant_src][head[grant_src]];
                cdb_src    <= grant_src;
                last_grant <= grant_src;
            end else begin
                cdb_valid  <= 1'b0;
            end
        end
    end

endmodule
